// File: rtl/filt_ppd_pkg.sv
// filt_ppd_pkg: shared constants, types and helpers for the polyphase
// decimation filter (filt_ppd). The optional pipeline stage in front of the
// accumulator is enabled by defining FILT_PPD_PIPE_EN.
package filt_ppd_pkg;

    localparam int C_IDATA_WIDTH  = 8;
    localparam int C_COEFF_WIDTH  = 16;
    localparam int C_COEFF_LENGTH = 8;
    localparam int C_ODATA_WIDTH  = C_IDATA_WIDTH + C_COEFF_WIDTH + $clog2(C_COEFF_LENGTH);
    localparam int C_IDX_WIDTH    = $clog2(C_COEFF_LENGTH);

    typedef logic signed [C_IDATA_WIDTH-1:0]               sample_t;
    typedef logic signed [C_IDATA_WIDTH+C_COEFF_WIDTH-1:0] product_t;
    typedef logic signed [C_ODATA_WIDTH-1:0]               acc_t;

    // Prototype impulse response h[0..N-1].
    localparam logic signed [C_COEFF_WIDTH-1:0] C_H [C_COEFF_LENGTH] = '{
        16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8
    };

    // Taps held by each branch: ceil(n/m).
    function automatic int f_taps_per_branch(input int n, input int m);
        return (n + m - 1) / m;
    endfunction

    // Coefficient j of an n-tap filter; taps past the end of the filter are zero.
    function automatic int f_coeff(input int j, input int n);
        if (j >= 0 && j < n && j < C_COEFF_LENGTH)
            return int'(C_H[j[C_IDX_WIDTH-1:0]]);
        return 0;
    endfunction

endpackage

// File: rtl/filt_ppd_if.sv
// filt_ppd_if: sample-in / decimated-sample-out bus of filt_ppd.
// The master drives samples, the slave (the filter) returns results.
interface filt_ppd_if #(
    parameter int gp_idata_width = 8,
    parameter int gp_odata_width = 27
);
    logic                             i_ena;
    logic signed [gp_idata_width-1:0] i_data;
    logic signed [gp_odata_width-1:0] o_data;
    logic                             o_valid;

    modport master (output i_ena, i_data, input  o_data, o_valid);
    modport slave  (input  i_ena, i_data, output o_data, o_valid);
endinterface

// File: rtl/filt_ppd_branch.sv
// filt_ppd_branch: one polyphase branch. Holds a K-entry delay line and
// produces the dot product of its coefficients h[k*M+p] with the line as it
// will look after the current shift.
module filt_ppd_branch
    import filt_ppd_pkg::*;
#(
    parameter int gp_idata_width       = 8,
    parameter int gp_coeff_width       = 16,
    parameter int gp_coeff_length      = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_odata_width       = 27,
    parameter int gp_branch            = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_shift,
    input  logic signed [gp_idata_width-1:0] i_data,
    output logic signed [gp_odata_width-1:0] o_partial
);
    localparam int K  = f_taps_per_branch(gp_coeff_length, gp_decimation_factor);
    localparam int PW = gp_idata_width + gp_coeff_width;

    logic signed [gp_idata_width-1:0] line [K];
    logic signed [gp_idata_width-1:0] taps [K];

    // Post-shift view of the delay line: new sample in slot 0.
    always_comb begin
        taps[0] = i_data;
        for (int k = 1; k < K; k++) taps[k] = line[k-1];
    end

    // Delay line advances only when this branch receives a sample.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees
        // pre-edge values. The delay line is cleared on reset as well, because
        // a reset must leave no residue of an earlier frame in later outputs.
        if (i_rst) begin
            for (int k = 0; k < K; k++) line[k] <= '0;
        end else if (i_shift) begin
            line <= taps;
        end
    end

    // Full-precision products, sign-extended and summed at output width.
    always_comb begin
        logic signed [gp_coeff_width-1:0] coef;
        logic signed [PW-1:0]             prod;
        // NOTE: every variable gets a value before any conditional/loop use so
        // no latch is inferred.
        coef      = '0;
        prod      = '0;
        o_partial = '0;
        for (int k = 0; k < K; k++) begin
            coef      = gp_coeff_width'(f_coeff(k * gp_decimation_factor + gp_branch, gp_coeff_length));
            prod      = taps[k] * coef;
            o_partial = o_partial + gp_odata_width'(prod);
        end
    end

endmodule

// File: rtl/filt_ppd.sv
// filt_ppd: polyphase decimation filter, M inputs per output.
// Define FILT_PPD_PIPE_EN to register the branch partial, the phase-end flag
// and the enable in front of the accumulator (latency 2 instead of 1).
module filt_ppd
    import filt_ppd_pkg::*;
#(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_coeff_length      = 8,
    parameter int gp_coeff_width       = 16,
    parameter int gp_comm_phase        = 0,
    parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
    input  logic     i_clk,
    input  logic     i_rst,
    filt_ppd_if.slave bus
);
    localparam int M    = gp_decimation_factor;
    localparam int PH_W = $clog2(M);

    logic [PH_W-1:0]                  phase;
    logic [PH_W-1:0]                  sel;
    logic                             last;
    logic [M-1:0]                     shift;
    logic signed [gp_odata_width-1:0] partials [M];
    logic signed [gp_odata_width-1:0] acc;

    logic                             acc_en;
    logic                             acc_last;
    logic signed [gp_odata_width-1:0] acc_part;

    assign last = (phase == PH_W'(M - 1));
    assign sel  = PH_W'(M - 1) - phase;

    for (genvar b = 0; b < M; b++) begin : g_branch
        assign shift[b] = bus.i_ena && (sel == PH_W'(b));

        filt_ppd_branch #(
            .gp_idata_width      (gp_idata_width),
            .gp_coeff_width      (gp_coeff_width),
            .gp_coeff_length     (gp_coeff_length),
            .gp_decimation_factor(M),
            .gp_odata_width      (gp_odata_width),
            .gp_branch           (b)
        ) u_branch (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_shift  (shift[b]),
            .i_data   (bus.i_data),
            .o_partial(partials[b])
        );
    end

    // Commutator: advances per accepted sample, wraps from M-1 to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst)          phase <= PH_W'(gp_comm_phase);
        else if (bus.i_ena) phase <= last ? '0 : phase + 1'b1;
    end

`ifdef FILT_PPD_PIPE_EN
    logic                             en_q;
    logic                             last_q;
    logic signed [gp_odata_width-1:0] part_q;

    // Pipeline stage between branch sum and accumulator; reset drops it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q   <= 1'b0;
            last_q <= 1'b0;
            part_q <= '0;
        end else begin
            en_q   <= bus.i_ena;
            last_q <= last;
            part_q <= partials[sel];
        end
    end

    assign acc_en   = en_q;
    assign acc_last = last_q;
    assign acc_part = part_q;
`else
    assign acc_en   = bus.i_ena;
    assign acc_last = last;
    assign acc_part = partials[sel];
`endif

    // Accumulate partials over a frame; dump to the output at frame end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            bus.o_data  <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            if (acc_en) begin
                if (acc_last) begin
                    bus.o_data  <= acc + acc_part;
                    bus.o_valid <= 1'b1;
                    acc         <= '0;
                end else begin
                    acc <= acc + acc_part;
                end
            end
        end
    end

endmodule

// File: tb/tb_filt_ppd.sv
// tb_filt_ppd: directed bench for filt_ppd (M=4, N=8, h=1..8). Two instances
// share the stimulus: commutator reset phase 0 and phase 2.
module tb_filt_ppd;
    import filt_ppd_pkg::*;

    localparam int OW = 27;
`ifdef FILT_PPD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ena = 1'b0;
    logic signed [7:0] din = '0;

    always #5 clk = ~clk;

    filt_ppd_if #(.gp_idata_width(8), .gp_odata_width(OW)) bus0 ();
    filt_ppd_if #(.gp_idata_width(8), .gp_odata_width(OW)) bus2 ();

    assign bus0.i_ena  = ena;
    assign bus0.i_data = din;
    assign bus2.i_ena  = ena;
    assign bus2.i_data = din;

    filt_ppd #(.gp_comm_phase(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    filt_ppd #(.gp_comm_phase(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    typedef struct {
        logic signed [OW-1:0] data;
        int                   cyc;
    } ev_t;

    ev_t log0[$];
    ev_t log2[$];
    int  acc_cyc[$];
    int  cyc   = 0;
    int  n_vec = 0;
    int  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output log, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus0.o_valid === 1'b1) log0.push_back('{bus0.o_data, cyc});
        if (bus2.o_valid === 1'b1) log2.push_back('{bus2.o_data, cyc});
    end

    task automatic step(input logic e, input logic signed [7:0] d, input logic r);
        @(negedge clk);
        ena = e;
        din = d;
        rst = r;
        if (e && !r) acc_cyc.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'sd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'sd0, 1'b1);
        step(1'b0, 8'sd0, 1'b0);
        log0.delete();
        log2.delete();
        acc_cyc.delete();
    endtask

    task automatic impulse();
        step(1'b1, 8'sd1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 8'sd0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 8'sd77, 1'b0);
        do_reset();
        n_vec++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid0: got %b expected 0", bus0.o_valid); end
        n_vec++; if (bus0.o_data !== '0)    begin n_err++; $display("FAIL reset o_data0: got %0d expected 0", bus0.o_data); end
        n_vec++; if (bus2.o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid2: got %b expected 0", bus2.o_valid); end
        n_vec++; if (bus2.o_data !== '0)    begin n_err++; $display("FAIL reset o_data2: got %0d expected 0", bus2.o_data); end
    endtask

    task automatic test_impulse();
        int exp_d[3] = '{4, 8, 0};
        do_reset();
        impulse();
        idle(4); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL impulse count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL impulse[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
            n_vec++; if (log0[i].cyc != acc_cyc[4*i+3] + LAT - 1) begin n_err++; $display("FAIL impulse[%0d] cycle: got %0d expected %0d", i, log0[i].cyc, acc_cyc[4*i+3] + LAT - 1); end
        end
    endtask

    task automatic test_step();
        int exp_d[3] = '{10, 36, 36};
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 8'sd1, 1'b0);
        idle(4); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL step count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL step[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
        end
        n_vec++; if (bus0.o_data !== OW'(36)) begin n_err++; $display("FAIL step hold: got %0d expected 36", bus0.o_data); end
        n_vec++; if (bus0.o_valid !== 1'b0)   begin n_err++; $display("FAIL step idle o_valid: got %b expected 0", bus0.o_valid); end
    endtask

    task automatic test_neg_full_scale();
        int exp_d[3] = '{-1280, -4608, -4608};
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, -8'sd128, 1'b0);
        idle(4); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL negfs count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL negfs[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
        end
    endtask

    task automatic test_enable_gaps();
        int exp_d[3] = '{4, 8, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i == 0) ? 8'sd1 : 8'sd0, 1'b0);
            idle(3);
        end
        idle(2); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL gaps count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL gaps[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
            n_vec++; if (log0[i].cyc != acc_cyc[4*i+3] + LAT - 1) begin n_err++; $display("FAIL gaps[%0d] cycle: got %0d expected %0d", i, log0[i].cyc, acc_cyc[4*i+3] + LAT - 1); end
        end
    endtask

    task automatic test_mid_frame_reset();
        int exp_d[3] = '{4, 8, 0};
        do_reset();
        step(1'b1, 8'sd5, 1'b0);
        step(1'b1, 8'sd5, 1'b0);
        step(1'b0, 8'sd0, 1'b1);
        acc_cyc.delete();
        impulse();
        idle(4); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL midreset count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL midreset[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
            n_vec++; if (log0[i].cyc != acc_cyc[4*i+3] + LAT - 1) begin n_err++; $display("FAIL midreset[%0d] cycle: got %0d expected %0d", i, log0[i].cyc, acc_cyc[4*i+3] + LAT - 1); end
        end
    endtask

    // Reset and a sample on the same edge: the sample must be dropped.
    task automatic test_reset_wins();
        int exp_d[3] = '{4, 8, 0};
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'sd3, 1'b0);
        step(1'b1, 8'sd9, 1'b1);
        log0.delete();
        acc_cyc.delete();
        impulse();
        idle(4); #1;
        n_vec++; if (log0.size() != 3) begin n_err++; $display("FAIL rstwins count: got %0d expected 3", log0.size()); end
        for (int i = 0; i < 3 && i < log0.size(); i++) begin
            n_vec++; if (log0[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL rstwins[%0d] data: got %0d expected %0d", i, log0[i].data, exp_d[i]); end
        end
    endtask

    // Reset on the edge right after the frame-end sample.
    task automatic test_inflight_reset();
        int exp_n;
        exp_n = (LAT == 1) ? 1 : 0;
        do_reset();
        step(1'b1, 8'sd1, 1'b0);
        step(1'b1, 8'sd2, 1'b0);
        step(1'b1, 8'sd3, 1'b0);
        step(1'b1, 8'sd4, 1'b0);
        step(1'b0, 8'sd0, 1'b1);
        idle(3); #1;
        n_vec++; if (log0.size() != exp_n) begin n_err++; $display("FAIL inflight count: got %0d expected %0d", log0.size(), exp_n); end
        if (log0.size() > 0) begin
            n_vec++; if (log0[0].data !== OW'(20)) begin n_err++; $display("FAIL inflight data: got %0d expected 20", log0[0].data); end
        end
        n_vec++; if (bus0.o_data !== '0) begin n_err++; $display("FAIL inflight o_data after reset: got %0d expected 0", bus0.o_data); end
    endtask

    task automatic test_comm_phase();
        int exp_d[3] = '{2, 6, 0};
        do_reset();
        impulse();
        idle(4); #1;
        n_vec++; if (log2.size() != 3) begin n_err++; $display("FAIL commphase count: got %0d expected 3", log2.size()); end
        for (int i = 0; i < 3 && i < log2.size(); i++) begin
            n_vec++; if (log2[i].data !== OW'(exp_d[i])) begin n_err++; $display("FAIL commphase[%0d] data: got %0d expected %0d", i, log2[i].data, exp_d[i]); end
            n_vec++; if (log2[i].cyc != acc_cyc[4*i+1] + LAT - 1) begin n_err++; $display("FAIL commphase[%0d] cycle: got %0d expected %0d", i, log2[i].cyc, acc_cyc[4*i+1] + LAT - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_neg_full_scale();
        test_enable_gaps();
        test_mid_frame_reset();
        test_reset_wins();
        test_inflight_reset();
        test_comm_phase();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/filt_ppd.md
# filt_ppd

Polyphase decimation filter, the receive-side counterpart of the polyphase interpolator. It accepts one signed input sample per `i_ena` strobe and routes consecutive samples across `gp_decimation_factor` branch delay lines. Each sample's branch dot product is accumulated, and one filtered output sample is emitted every `gp_decimation_factor` accepted inputs. It sits between a fast-rate sample source (CIC or modulator output) and slow-rate downstream processing, in one clock domain.

## Interface
- `gp_idata_width`, 8, input sample width, signed
- `gp_decimation_factor`, 4, M: inputs per output, ≥2
- `gp_coeff_length`, 8, N: total filter taps
- `gp_coeff_width`, 16, coefficient width, signed
- `gp_comm_phase`, 0, reset value of the commutator phase counter, 0..M-1
- `gp_odata_width`, `gp_idata_width+gp_coeff_width+$clog2(gp_coeff_length)`, output width, signed
- `i_clk`  in  1  rising-edge clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_ena`  in  1  input sample strobe; `i_data` is accepted on each cycle where this is high
- `i_data`  in  gp_idata_width  input sample, signed
- `o_data`  out  gp_odata_width  decimated output sample, signed, held between strobes
- `o_valid`  out  1  one-cycle pulse when `o_data` updates

## Operation
- K = ceil(N/M) taps per branch. Coefficients h[j] for j ≥ N are treated as 0.
- Phase counter c counts 0..M-1 and advances only on accepted samples, wrapping from M-1 to 0.
- An accepted sample at phase c goes to branch p = M-1-c:
  - It shifts into that branch's K-entry delay line at slot 0 (newest); the other branches are untouched.
  - The branch partial is computed as sum over k of h[kM+p]·line_p[k], using the post-shift contents.
- Accumulator:
  - If c < M-1: acc += partial.
  - If c = M-1: the output register is loaded with acc+partial, acc is cleared, and `o_valid` pulses.
- Resulting transfer function: y = Σ_{j=0}^{N-1} h[j]·x[n-j], where n is the sample accepted at c = M-1.
- Arithmetic:
  - Products are full precision, gp_idata_width+gp_coeff_width bits.
  - The sum and acc are gp_odata_width bits, sign-extended.
  - There is no rounding or saturation. The default width is overflow-free.
- `i_ena` low: all state holds and `o_valid` is 0. Gaps between samples do not change the output sequence.
- Reset, including mid-frame:
  - Delay lines, acc, `o_data` and `o_valid` are cleared to 0.
  - c is set to `gp_comm_phase`.
  - A frame in progress is discarded.
- `gp_comm_phase` = q means the first output comes after M-q accepted samples, aligning the decimation instant.

## Timing
- Without `FILT_PPD_PIPE_EN`: `o_data`/`o_valid` are registered and appear on the cycle after the i_ena edge that accepts the c = M-1 sample. Latency is 1.
- With `FILT_PPD_PIPE_EN`: latency is 2 (see Configuration).
- Throughput is one sample per cycle; `i_ena` may be held high continuously.
- If `i_rst` and `i_ena` are high on the same edge, reset wins and the sample is dropped.
- If reset arrives while a pipelined result is in flight, the result is dropped and `o_valid` stays 0.

## Configuration
- `FILT_PPD_PIPE_EN`, when defined:
  - The branch partial, the phase-end flag and an enable are registered before the accumulator.
  - Latency is 2, the critical path is shorter, and the output sequence is identical to the unpipelined build.
- When undefined: partial feeds the accumulator combinationally and latency is 1.

## Structure
- Package `filt_ppd_pkg`:
  - Coefficient array constant h[0..N-1] (gp_coeff_width signed).
  - Function `f_taps_per_branch(N,M)` returning ceil(N/M).
  - Typedefs for sample, product and accumulator widths.
- Sub-module `filt_ppd_branch` (one instance per phase, generate loop):
  - Contains the K-entry delay line with shift enable, plus K coefficient taps selected by branch index p.
  - Outputs the partial sum.
- The top level holds the phase counter, partial mux, accumulator and output register.

## Test plan
Defaults M=4, N=8, h = 1..8, gp_comm_phase = 0.
- Impulse: x = 1, then zeros → o_valid after the 4th sample with o_data = 4, then 8, then 0 thereafter.
- Step: all x = 1 → outputs 10, 36, 36, …
- Negative full scale: x = −128 continuously → steady o_data = −4608, no overflow.
- Enable gaps: impulse with 3 idle cycles between samples → same outputs 4, 8, 0, and o_valid only after each 4th accepted sample.
- Mid-frame reset: 2 samples of value 5, then i_rst for one cycle, then the impulse → exactly the impulse response, no residue.
- gp_comm_phase = 2: impulse → first o_valid after 2 samples with o_data = 2, then 6, then 0. Repeat with `FILT_PPD_PIPE_EN` defined → identical values, each one cycle later.
